// File: rtl/clkdiv_multi_if.sv
// Half-period load port for clkdiv_multi.
// Master drives a channel/half-period request, slave answers with ready.
interface clkdiv_multi_if #(
  parameter int CH = 4,
  parameter int W  = 32
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic          cfg_valid;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_half;
  logic          cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_half,
    output cfg_ready
  );
endinterface

// File: rtl/clkdiv_multi.sv
// Multi-channel 50%-duty clock divider with shadowed half-period reload.
// Optional CLKDIV_TICK_EN macro enables the per-channel toggle tick.
module clkdiv_multi #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int DEFAULT_FREQ = 1,
  parameter int CH           = 4,
  parameter int W            = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          sync,
  clkdiv_multi_if.slave cfg,
  output logic [CH-1:0] clk_div,
  output logic [CH-1:0] tick
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int DH = CLK_FREQ / (2 * DEFAULT_FREQ);
  localparam logic [W-1:0] DEFAULT_HALF =
    (DH < 1) ? W'(1) : W'(DH);

  logic [CH-1:0] pend;
  logic          ready_c;

  // Out-of-range channel numbers never match and read as ready.
  always_comb begin
    ready_c = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (cfg.cfg_ch == CW'(i)) ready_c = ~pend[i];
    end
  end

  assign cfg.cfg_ready = ready_c;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [W-1:0] cnt_q;
    logic [W-1:0] act_q;
    logic [W-1:0] sh_q;
    logic         pend_q;
    logic         div_q;
    logic         bnd;
    logic         hold;
    logic         load;
    logic         apply;

    assign bnd   = (cnt_q == act_q - W'(1));
    assign hold  = sync | ~en[g];
    assign load  = cfg.cfg_valid
                 & (cfg.cfg_ch == CW'(g))
                 & ~pend_q;
    // Shadow only moves to act on a toggle boundary or while held idle.
    assign apply = pend_q & (hold | bnd);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= '0;
        act_q  <= DEFAULT_HALF;
        sh_q   <= '0;
        pend_q <= 1'b0;
        div_q  <= 1'b0;
      end else begin
        if (hold) begin
          cnt_q <= '0;
          div_q <= 1'b0;
        end else if (bnd) begin
          cnt_q <= '0;
          div_q <= ~div_q;
        end else begin
          cnt_q <= cnt_q + W'(1);
        end
        if (apply) begin
          act_q  <= sh_q;
          pend_q <= 1'b0;
        end else if (load) begin
          sh_q   <= (cfg.cfg_half == '0) ? W'(1) : cfg.cfg_half;
          pend_q <= 1'b1;
        end
      end
    end

    assign pend[g]    = pend_q;
    assign clk_div[g] = div_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= ~hold & bnd;
      end
    end

    assign tick[g] = tick_q;
`else
    assign tick[g] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: 2 channels, default half-period 5.
// Tick expectations follow whether CLKDIV_TICK_EN is defined.
module tb_clkdiv_multi;
  localparam int CH = 2;
  localparam int W  = 16;

`ifdef CLKDIV_TICK_EN
  localparam bit TK = 1'b1;
`else
  localparam bit TK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [CH-1:0] en;
  logic          sync;
  logic [CH-1:0] clk_div;
  logic [CH-1:0] tick;

  int vecs;
  int errs;

  clkdiv_multi_if #(.CH(CH), .W(W)) cfg ();

  clkdiv_multi #(
    .CLK_FREQ    (100),
    .DEFAULT_FREQ(10),
    .CH          (CH),
    .W           (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .cfg    (cfg.slave),
    .clk_div(clk_div),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp)
    else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] tk(input logic [1:0] v);
    return TK ? v : 2'b00;
  endfunction

  task automatic outs(input string tag,
                      input logic [1:0] d,
                      input logic [1:0] t);
    chk({tag, ".div"}, 32'(clk_div), 32'(d));
    chk({tag, ".tick"}, 32'(tick), 32'(tk(t)));
  endtask

  task automatic out0(input string tag,
                      input logic d,
                      input logic t);
    chk({tag, ".div0"}, 32'(clk_div[0]), 32'(d));
    chk({tag, ".tick0"}, 32'(tick[0]), 32'(TK & t));
  endtask

  task automatic rdy(input string tag, input logic r);
    #1;
    chk({tag, ".rdy"}, 32'(cfg.cfg_ready), 32'(r));
  endtask

  initial begin
    vecs          = 0;
    errs          = 0;
    rst           = 1'b0;
    en            = 2'b00;
    sync          = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = 1'b0;
    cfg.cfg_half  = '0;

    // reset state
    step(2);
    outs("rst", 2'b00, 2'b00);
    chk("rst.cnt0", 32'(dut.g_ch[0].cnt_q), 0);
    rdy("rst", 1'b1);
    rst = 1'b1;
    step(1);
    outs("idle", 2'b00, 2'b00);

    // default half 5: rise 5 cycles after en
    en = 2'b11;
    step(4);
    outs("en.c4", 2'b00, 2'b00);
    step(1);
    outs("en.c5", 2'b11, 2'b11);
    step(1);
    outs("en.c6", 2'b11, 2'b00);
    step(4);
    outs("en.c10", 2'b00, 2'b11);

    // mid-period load of 3 on ch0
    step(2);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 1'b0;
    cfg.cfg_half  = 16'd3;
    rdy("ld3.pre", 1'b1);
    step(1);
    cfg.cfg_valid = 1'b0;
    rdy("ld3.acc", 1'b0);
    step(1);
    outs("ld3.c14", 2'b00, 2'b00);
    rdy("ld3.c14", 1'b0);
    step(1);
    outs("ld3.bnd", 2'b11, 2'b11);
    rdy("ld3.bnd", 1'b1);
    step(2);
    outs("ld3.c17", 2'b11, 2'b00);
    step(1);
    outs("ld3.c18", 2'b10, 2'b01);
    step(2);
    outs("ld3.c20", 2'b00, 2'b10);
    step(1);
    outs("ld3.c21", 2'b01, 2'b01);

    // half 0 on ch1 clamps to 1
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 1'b1;
    cfg.cfg_half  = 16'd0;
    step(1);
    cfg.cfg_valid = 1'b0;
    sync          = 1'b1;
    step(1);
    sync = 1'b0;
    outs("h0.sync", 2'b00, 2'b00);
    step(1);
    outs("h0.c1", 2'b10, 2'b10);
    step(1);
    outs("h0.c2", 2'b00, 2'b10);
    step(1);
    outs("h0.c3", 2'b11, 2'b11);

    // load on boundary, second load stalls while pending
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    step(2);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 1'b0;
    cfg.cfg_half  = 16'd6;
    rdy("bl.pre", 1'b1);
    step(1);
    cfg.cfg_half = 16'd2;
    rdy("bl.2nd", 1'b0);
    out0("bl.c3", 1'b1, 1'b1);
    step(2);
    out0("bl.c5", 1'b1, 1'b0);
    rdy("bl.c5", 1'b0);
    step(1);
    out0("bl.c6", 1'b0, 1'b1);
    rdy("bl.c6", 1'b1);
    step(1);
    cfg.cfg_valid = 1'b0;
    rdy("bl.c7", 1'b0);
    step(4);
    out0("bl.c11", 1'b0, 1'b0);
    step(1);
    out0("bl.c12", 1'b1, 1'b1);
    rdy("bl.c12", 1'b1);
    step(1);
    out0("bl.c13", 1'b1, 1'b0);
    step(1);
    out0("bl.c14", 1'b0, 1'b1);

    // halves 5 and 7, then sync
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 1'b0;
    cfg.cfg_half  = 16'd5;
    step(1);
    cfg.cfg_ch   = 1'b1;
    cfg.cfg_half = 16'd7;
    step(1);
    cfg.cfg_valid = 1'b0;
    step(3);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    outs("sy.c0", 2'b00, 2'b00);
    step(4);
    outs("sy.c4", 2'b00, 2'b00);
    step(1);
    outs("sy.c5", 2'b01, 2'b01);
    step(2);
    outs("sy.c7", 2'b11, 2'b10);
    step(3);
    outs("sy.c10", 2'b10, 2'b01);

    // asynchronous reset mid-period
    step(2);
    #2;
    rst = 1'b0;
    #1;
    outs("ar", 2'b00, 2'b00);
    chk("ar.cnt0", 32'(dut.g_ch[0].cnt_q), 0);
    chk("ar.cnt1", 32'(dut.g_ch[1].cnt_q), 0);
    step(1);
    rst = 1'b1;
    rdy("ar.rel", 1'b1);
    step(4);
    outs("ar.c4", 2'b00, 2'b00);
    step(1);
    outs("ar.c5", 2'b11, 2'b11);

    // disabling a channel forces it low
    en = 2'b01;
    step(1);
    outs("dis", 2'b01, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel clock divider, next generation of the fixed single-output divider in the PWM path. Each of CH channels produces a 50%-duty divided clock plus a one-cycle toggle tick, with a runtime-programmable half-period loaded through a valid/ready port. New half-periods are applied glitch-free at the channel's next toggle boundary. A global sync input phase-aligns all channels. Feeds PWM generators and slow-tick consumers.

## Interface
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- DEFAULT_FREQ, 1: reset output frequency in Hz; reset half-period DEFAULT_HALF = CLK_FREQ/(2*DEFAULT_FREQ), clamped to ≥1.
- CH, 4: channel count, ≥1.
- W, 32: half-period/counter width.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  CH  per-channel run enable.
- sync  in  1  synchronous phase-align strobe, all channels.
- cfg_valid  in  1  half-period load request.
- cfg_ch  in  max(1,$clog2(CH))  target channel; values ≥CH are accepted and discarded.
- cfg_half  in  W  new half-period in clk cycles.
- cfg_ready  out  1  = ~pending[cfg_ch] (combinational); 1 for out-of-range cfg_ch.
- clk_div  out  CH  divided clocks.
- tick  out  CH  one-cycle pulse on every clk_div toggle.

## Operation
- Per channel: counter count[W], active half act[W], shadow sh[W], pending flag.
- Reset (rst low): count=0, act=DEFAULT_HALF, sh=0, pending=0, clk_div=0, tick=0.
- Load: cfg_valid & cfg_ready → sh=(cfg_half==0 ? 1 : cfg_half), pending=1. cfg_half 0 clamps to 1 (clk/2 output).
- Running (en=1): count increments each cycle. When count==act-1 (boundary): count=0, clk_div toggles, tick=1; if pending, act=sh and pending=0.
- Disabled (en=0): count=0, clk_div=0, tick=0; pending shadow applied next cycle (act=sh, pending=0).
- sync=1: all channels count=0, clk_div=0, tick=0; all pending shadows applied; overrides boundary in the same cycle.
- Priority per channel: rst > sync > en=0 > boundary > increment.
- Load accepted in the same cycle as a boundary: sh captured, applied at the following boundary, never the current one.
- Load while pending=1 stalls (cfg_ready=0); no overwrite.
- Counter never wraps: act ≥1, compare is count==act-1.

## Timing
- Output period = 2*act cycles, duty exactly 50%.
- clk_div and tick are registered; tick asserted in the exact cycle clk_div shows its new value, for one cycle.
- After en rises (or sync/reset release with en=1), first toggle is act cycles later: clk_div rises at cycle act, falls at 2*act.
- act=1: clk_div toggles every cycle, tick held high continuously.
- New act takes effect starting with the half-period after the boundary that applied it; no short or runt half-periods.
- cfg_ready drops the cycle after acceptance; recovers the cycle after application.

## Configuration
- CLKDIV_TICK_EN defined: tick port driven as specified.
- Not defined: tick tied to 0, tick registers removed; clk_div behaviour unchanged.

## Test plan
- CLK_FREQ=100, DEFAULT_FREQ=10, CH=2, en=3 after reset → both clk_div period 10 cycles, first rise 5 cycles after en; tick pulses every 5 cycles (TICK_EN defined).
- Ch0 running half=5, load cfg_half=3 mid-period → current half-period finishes at 5, then 3-cycle half-periods; cfg_ready low from acceptance until that boundary.
- Load cfg_half=0 on ch1 → ch1 toggles every cycle, tick stuck high.
- Load accepted exactly on boundary cycle, second load attempted while pending → old half used one more half-period; second load held (cfg_ready=0) until applied.
- Channels at half 5 and 7 free-running, pulse sync → both clk_div=0 next cycle, both rise 5 and 7 cycles later respectively.
- rst asserted mid-period → clk_div, tick, count 0 immediately (asynchronous); act=DEFAULT_HALF after release; build without CLKDIV_TICK_EN → tick always 0.
